// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// waits on memory handshakes, halts on illegal opcode or memory timeout, counts retires.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_sel,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    WB_ALU = 3'd5,
    WB_MEM = 3'd6,
    HALT   = 3'd7
  } stateT;

  stateT             stateQ;
  stateT             stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic              illegalQ;
  logic              timeoutQ;
  logic [CNT_W-1:0]  instretQ;
  logic              opLegal;
  logic              isMemState;
  logic              memExpired;
  logic              retire;
  logic              setIllegal;

  // Opcode legality and memory-wait status
  always_comb begin
    opLegal    = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                 (opcode == OP_ST) || (opcode == OP_BR);
    isMemState = (stateQ == FETCH) || (stateQ == MEM_RD) || (stateQ == MEM_WR);
    memExpired = isMemState && !mem_ready && (waitCnt == WAIT_W'(MEM_TIMEOUT));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= FETCH;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Next-state logic; mem_ready in the boundary cycle beats the timeout
  always_comb begin
    stateNext  = stateQ;
    retire     = 1'b0;
    setIllegal = 1'b0;
    case (stateQ)
      FETCH: begin
        if (mem_ready)       stateNext = DECODE;
        else if (memExpired) stateNext = HALT;
      end
      DECODE: begin
        if (opLegal) begin
          stateNext = EXEC;
        end else begin
          stateNext  = HALT;
          setIllegal = 1'b1;
        end
      end
      EXEC: begin
        case (opcode)
          OP_R, OP_I: stateNext = WB_ALU;
          OP_LD:      stateNext = MEM_RD;
          OP_ST:      stateNext = MEM_WR;
          OP_BR: begin
            stateNext = FETCH;
            retire    = 1'b1;
          end
          default: begin
            stateNext  = HALT;
            setIllegal = 1'b1;
          end
        endcase
      end
      MEM_RD: begin
        if (mem_ready)       stateNext = WB_MEM;
        else if (memExpired) stateNext = HALT;
      end
      MEM_WR: begin
        if (mem_ready) begin
          stateNext = FETCH;
          retire    = 1'b1;
        end else if (memExpired) begin
          stateNext = HALT;
        end
      end
      WB_ALU, WB_MEM: begin
        stateNext = FETCH;
        retire    = 1'b1;
      end
      HALT:    stateNext = HALT;
      default: stateNext = HALT;
    endcase
  end

  // Wait counter, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCnt  <= '0;
      illegalQ <= 1'b0;
      timeoutQ <= 1'b0;
      instretQ <= '0;
    end else begin
      if (!isMemState || mem_ready || (stateNext != stateQ)) begin
        waitCnt <= '0;
      end else begin
        waitCnt <= waitCnt + WAIT_W'(1);
      end
      if (setIllegal) illegalQ <= 1'b1;
      if (memExpired) timeoutQ <= 1'b1;
      if (retire)     instretQ <= instretQ + CNT_W'(1);
    end
  end

  // Datapath control decode; strobes are gated off while reset is held
  always_comb begin
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_sel    = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (stateQ)
      FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_ST:   imm_sel = 2'b01;
          OP_BR:   imm_sel = 2'b10;
          default: imm_sel = 2'b00;
        endcase
      end
      EXEC: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
          end
          OP_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
          end
          OP_LD, OP_ST: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
          end
          OP_BR: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 1'b1;
            pc_write  = zero;
          end
          default: ;
        endcase
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      WB_ALU:  reg_write = 1'b1;
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state   = stateQ;
  assign halted  = (stateQ == HALT);
  assign illegal = illegalQ;
  assign timeout = timeoutQ;
  assign instret = instretQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, directed corner sequences, and random
// stimulus against an instruction-route reference model.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 8;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic          clk = 1'b0;
  logic          rst_n, zero, mem_ready;
  logic [6:0]    opcode;
  logic          mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src;
  logic          alu_src_a, reg_write, mem_to_reg, halted, illegal, timeout;
  logic [1:0]    alu_src_b, alu_op, imm_sel;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .state(state), .halted(halted), .illegal(illegal),
    .timeout(timeout), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, rd, wr, iord, irw, pcw, pcs, srcA;
    logic [1:0] srcB, aluOp, imm;
    logic       rw, m2r;
    logic [2:0] st;
    logic       hlt, ill, tmo;
    logic [7:0] ret;
  } obsT;

  typedef struct {
    logic       r;
    logic [6:0] op;
    logic       z, rdy;
    logic [2:0] st;
    logic       rw, mw, pcw;
    logic [7:0] ret;
  } vecT;

  int  tests = 0;
  int  fails = 0;
  obsT lastObs;

  // Reference model: per-class route of states, walked one step per completed cycle
  int route[5][5];
  int rlen[5];
  int mStep = 0, mCls = 0, mWait = 0, mRet = 0;
  bit mHalt = 1'b0, mIll = 1'b0, mTo = 1'b0;

  function automatic int clsOf(input logic [6:0] op);
    case (op)
      OP_R:    return 0;
      OP_I:    return 1;
      OP_LD:   return 2;
      OP_ST:   return 3;
      OP_BR:   return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int mCur();
    if (mHalt) return 7;
    if (mStep < 2) return mStep;
    return route[mCls][mStep];
  endfunction

  function automatic obsT observe();
    obsT o;
    o = '{req: mem_req, rd: mem_read, wr: mem_write, iord: i_or_d, irw: ir_write,
          pcw: pc_write, pcs: pc_src, srcA: alu_src_a, srcB: alu_src_b, aluOp: alu_op,
          imm: imm_sel, rw: reg_write, m2r: mem_to_reg, st: state, hlt: halted,
          ill: illegal, tmo: timeout, ret: instret};
    return o;
  endfunction

  function automatic obsT modelObs();
    obsT e;
    int  s;
    e = '0;
    s = mCur();
    case (s)
      0: begin e.req = 1; e.rd = 1; e.srcB = 2'b01; e.irw = mem_ready; e.pcw = mem_ready; end
      1: begin
        e.srcB = 2'b11;
        if (opcode == OP_ST) e.imm = 2'b01;
        else if (opcode == OP_BR) e.imm = 2'b10;
      end
      2: begin
        case (clsOf(opcode))
          0: begin e.srcA = 1; e.aluOp = 2'b10; end
          1: begin e.srcA = 1; e.srcB = 2'b10; e.aluOp = 2'b10; end
          2, 3: begin e.srcA = 1; e.srcB = 2'b10; end
          4: begin e.srcA = 1; e.aluOp = 2'b01; e.pcs = 1; e.pcw = zero; end
          default: ;
        endcase
      end
      3: begin e.req = 1; e.rd = 1; e.iord = 1; end
      4: begin e.req = 1; e.wr = 1; e.iord = 1; end
      5: e.rw = 1;
      6: begin e.rw = 1; e.m2r = 1; end
      default: ;
    endcase
    e.st  = 3'(s);
    e.hlt = mHalt;
    e.ill = mIll;
    e.tmo = mTo;
    e.ret = 8'(mRet);
    if (!rst_n) begin
      e.req = 0; e.rd = 0; e.wr = 0; e.irw = 0; e.pcw = 0; e.rw = 0;
    end
    return e;
  endfunction

  task automatic modelStep();
    int s;
    int c;
    if (!rst_n) begin
      mStep = 0; mWait = 0; mRet = 0; mHalt = 0; mIll = 0; mTo = 0;
      return;
    end
    if (mHalt) return;
    s = mCur();
    if ((s == 0 || s == 3 || s == 4) && !mem_ready) begin
      if (mWait == int'(TO)) begin
        mHalt = 1; mTo = 1;
      end else begin
        mWait++;
      end
      return;
    end
    mWait = 0;
    if (s == 1 || s == 2) begin
      c = clsOf(opcode);
      if (c < 0) begin
        mHalt = 1; mIll = 1;
        return;
      end
      mCls = c;
    end
    mStep++;
    if (mStep == rlen[mCls]) begin
      mStep = 0;
      mRet  = (mRet + 1) % (1 << CW);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive after the falling edge, sample before the rising edge
  task automatic tick(input logic r, input logic [6:0] op, input logic z, input logic rdy);
    @(negedge clk);
    rst_n = r; opcode = op; zero = z; mem_ready = rdy;
    #1;
    lastObs = observe();
    check("model", 64'(lastObs), 64'(modelObs()));
    modelStep();
  endtask

  vecT        vt[$];
  logic [2:0] ldSt [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd6, 3'd0};
  logic       ldRdy[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int         irwCnt;
    logic       bad;
    int         stuck;
    int         hcnt;
    logic [6:0] rop;
    logic       rr, rrdy;
    logic [6:0] legalOps [5];

    route[0] = '{0, 1, 2, 5, 0}; rlen[0] = 4;
    route[1] = '{0, 1, 2, 5, 0}; rlen[1] = 4;
    route[2] = '{0, 1, 2, 3, 6}; rlen[2] = 5;
    route[3] = '{0, 1, 2, 4, 0}; rlen[3] = 4;
    route[4] = '{0, 1, 2, 0, 0}; rlen[4] = 3;
    legalOps = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};

    rst_n = 0; opcode = '0; zero = 0; mem_ready = 0;
    repeat (2) @(posedge clk);

    // Reset state
    tick(0, OP_R, 0, 1);
    check("reset", 64'({lastObs.st, lastObs.hlt, lastObs.ill, lastObs.tmo, lastObs.req,
                        lastObs.irw, lastObs.pcw, lastObs.ret}), 64'(0));

    // R-type, store, BEQ taken, BEQ not taken with zero-wait memory
    vt.push_back('{1, OP_R,  0, 1, 3'd0, 0, 0, 1, 8'd0});
    vt.push_back('{1, OP_R,  0, 1, 3'd1, 0, 0, 0, 8'd0});
    vt.push_back('{1, OP_R,  0, 1, 3'd2, 0, 0, 0, 8'd0});
    vt.push_back('{1, OP_R,  0, 1, 3'd5, 1, 0, 0, 8'd0});
    vt.push_back('{1, OP_ST, 0, 1, 3'd0, 0, 0, 1, 8'd1});
    vt.push_back('{1, OP_ST, 0, 1, 3'd1, 0, 0, 0, 8'd1});
    vt.push_back('{1, OP_ST, 0, 1, 3'd2, 0, 0, 0, 8'd1});
    vt.push_back('{1, OP_ST, 0, 1, 3'd4, 0, 1, 0, 8'd1});
    vt.push_back('{1, OP_BR, 1, 1, 3'd0, 0, 0, 1, 8'd2});
    vt.push_back('{1, OP_BR, 1, 1, 3'd1, 0, 0, 0, 8'd2});
    vt.push_back('{1, OP_BR, 1, 1, 3'd2, 0, 0, 1, 8'd2});
    vt.push_back('{1, OP_BR, 0, 1, 3'd0, 0, 0, 1, 8'd3});
    vt.push_back('{1, OP_BR, 0, 1, 3'd1, 0, 0, 0, 8'd3});
    vt.push_back('{1, OP_BR, 0, 1, 3'd2, 0, 0, 0, 8'd3});
    vt.push_back('{1, OP_R,  0, 1, 3'd0, 0, 0, 1, 8'd4});
    foreach (vt[i]) begin
      tick(vt[i].r, vt[i].op, vt[i].z, vt[i].rdy);
      check("vector", 64'({lastObs.st, lastObs.rw, lastObs.wr, lastObs.pcw, lastObs.ret}),
            64'({vt[i].st, vt[i].rw, vt[i].mw, vt[i].pcw, vt[i].ret}));
    end

    // Load with three wait cycles in both FETCH and MEM_RD
    tick(0, OP_LD, 0, 0);
    irwCnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1, OP_LD, 0, ldRdy[i]);
      check("load_state", 64'(lastObs.st), 64'(ldSt[i]));
      irwCnt += int'(lastObs.irw);
    end
    check("load_irw", 64'(irwCnt), 64'(1));
    check("load_ret", 64'(lastObs.ret), 64'(1));

    // Illegal opcode halts and holds until reset
    tick(0, 7'h7f, 0, 0);
    tick(1, 7'h7f, 0, 1);
    tick(1, 7'h7f, 0, 0);
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      tick(1, 7'h7f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (lastObs.st != 3'd7 || !lastObs.hlt || !lastObs.ill || lastObs.tmo ||
          lastObs.req || lastObs.rd || lastObs.wr || lastObs.irw || lastObs.pcw || lastObs.rw)
        bad = 1;
    end
    check("illegal_hold", 64'(bad), 64'(0));
    tick(0, OP_R, 0, 0);
    tick(1, OP_R, 0, 0);
    check("illegal_clear", 64'({lastObs.st, lastObs.hlt, lastObs.ill, lastObs.tmo}), 64'(0));

    // Store stuck in MEM_WR times out
    tick(0, OP_ST, 0, 0);
    tick(1, OP_ST, 0, 1);
    tick(1, OP_ST, 0, 0);
    tick(1, OP_ST, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, OP_ST, 0, 0);
    check("to_last_wait", 64'({lastObs.st, lastObs.wr, lastObs.tmo}), 64'({3'd4, 1'b1, 1'b0}));
    tick(1, OP_ST, 0, 0);
    check("to_halt", 64'({lastObs.st, lastObs.hlt, lastObs.tmo, lastObs.wr, lastObs.req}),
          64'({3'd7, 1'b1, 1'b1, 1'b0, 1'b0}));

    // Ready on the boundary cycle wins over the timeout
    tick(0, OP_ST, 0, 0);
    tick(1, OP_ST, 0, 1);
    tick(1, OP_ST, 0, 0);
    tick(1, OP_ST, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, OP_ST, 0, 0);
    tick(1, OP_ST, 0, 1);
    check("to_boundary", 64'({lastObs.st, lastObs.wr}), 64'({3'd4, 1'b1}));
    tick(1, OP_R, 0, 0);
    check("to_avoided", 64'({lastObs.st, lastObs.tmo, lastObs.hlt, lastObs.ret}),
          64'({3'd0, 1'b0, 1'b0, 8'd1}));

    // Reset in the middle of MEM_RD aborts without retiring
    tick(0, OP_LD, 0, 0);
    tick(1, OP_LD, 0, 1);
    tick(1, OP_LD, 0, 0);
    tick(1, OP_LD, 0, 0);
    tick(1, OP_LD, 0, 0);
    tick(1, OP_LD, 0, 0);
    tick(0, OP_LD, 0, 1);
    check("rst_mid_req", 64'({lastObs.st, lastObs.req, lastObs.rd}), 64'({3'd3, 1'b0, 1'b0}));
    tick(1, OP_LD, 0, 0);
    check("rst_mid_after", 64'({lastObs.st, lastObs.ret}), 64'({3'd0, 8'd0}));

    // Random instruction mix with random memory latency against the model
    tick(0, OP_R, 0, 0);
    stuck = 0;
    hcnt  = 0;
    rop   = OP_R;
    for (int n = 0; n < 3000; n++) begin
      if (mCur() == 0 || mHalt) begin
        if ($urandom_range(0, 9) == 0) rop = 7'($urandom());
        else rop = legalOps[$urandom_range(0, 4)];
      end
      if (stuck > 0) begin
        rrdy = 0;
        stuck--;
      end else begin
        rrdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) stuck = 6;
      end
      hcnt = mHalt ? hcnt + 1 : 0;
      rr   = !(hcnt > 3 || $urandom_range(0, 299) == 0);
      tick(rr, rop, 1'($urandom_range(0, 1)), rrdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath: shared ALU, single memory port, instruction register (IR), and an ALUOut holding register.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on memory-ready handshakes.
- Halts on an illegal opcode or a memory timeout; counts retired instructions.
- Sits beside regFile, immGen and ALUControl, replacing the single-cycle controlUnit decode.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request may wait for ready before HALT (1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- opcode  in  7  IR[6:0]; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_read  out  1  read request; instruction fetch or load
- mem_write  out  1  store request
- i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load IR from memory data
- pc_write  out  1  PC load enable
- pc_src  out  1  0 = ALU result, 1 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = imm, 11 = imm<<1
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- imm_sel  out  2  00 = I, 01 = S, 10 = B, 11 = unused
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  1 = writeback from memory data
- state  out  3  current state encoding
- halted  out  1  sticky halt
- illegal  out  1  sticky: halted on illegal opcode
- timeout  out  1  sticky: halted on memory timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: on a rising edge with rst_n=0:
  - state=FETCH, instret=0, wait counter=0, halted/illegal/timeout=0.
  - While rst_n=0, all strobe outputs are forced 0 combinationally (mem_req, mem_read, mem_write, ir_write, pc_write, reg_write).
  - Reset mid-instruction aborts it; no retire is counted.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB_ALU=5, WB_MEM=6, HALT=7.
- Default for any output not named in a state: 0.
- FETCH:
  - Drives mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - When mem_ready=1: ir_write=1 and pc_write=1 (pc_src=0, so PC<=PC+4), then -> DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00, so ALUOut latches the branch target.
  - imm_sel: load/I-ALU=00, store=01, branch=10.
  - Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011; legal -> EXEC.
  - Any other opcode -> HALT, setting illegal.
- EXEC:
  - R (0110011): a=1, b=00, op=10 -> WB_ALU.
  - I-ALU (0010011): a=1, b=10, op=10 -> WB_ALU.
  - Load/store: a=1, b=10, op=00 -> MEM_RD or MEM_WR.
  - Branch (BEQ): a=1, b=00, op=01, pc_src=1, pc_write=zero (combinational from the zero input) -> FETCH; retires.
- MEM_RD: mem_req=1, mem_read=1, i_or_d=1. When mem_ready=1 -> WB_MEM.
- MEM_WR: mem_req=1, mem_write=1, i_or_d=1. When mem_ready=1 -> FETCH; retires.
- WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH; retires.
- WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH; retires.
- Request holding: mem_req and address/type select are held stable until mem_ready. mem_ready sampled outside FETCH/MEM_RD/MEM_WR is ignored.
- Timeout:
  - The wait counter clears on entry to any memory state and on mem_ready.
  - It increments on each cycle in a memory state with mem_ready=0.
  - When it equals MEM_TIMEOUT and mem_ready=0 -> HALT, setting timeout. mem_ready in that same cycle wins: normal transition, no timeout.
- HALT: all strobes 0, halted=1. Exit only by reset.
- instret: +1 on each retire transition (the "retires" arrows above); wraps modulo 2^CNT_W without a flag.
- Latency with zero-wait memory (mem_ready=1 in first request cycle):
  - R and I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.

Test Plan:
- Reset, then R-type add, mem_ready always 1 -> states 0,1,2,5,0; reg_write high only in the WB_ALU cycle; instret=1 after 4 cycles.
- Load with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> fetch held 4 cycles, then 1,2,3 (held 4 cycles),6,0; ir_write pulses exactly once; instret=1 after 11 cycles.
- BEQ with zero=1, then BEQ with zero=0 -> pc_write=1 with pc_src=1 in the first EXEC cycle; pc_write=0 in the second; both retire, instret=2.
- Opcode 1111111 in DECODE -> HALT next cycle, illegal=1, halted=1, all strobes 0 for 20+ cycles; then rst_n=0 for one edge -> FETCH, flags cleared.
- MEM_TIMEOUT=4, mem_ready stuck 0 in MEM_WR -> HALT after the counter reaches 4, timeout=1, mem_write drops the same edge; repeat with mem_ready=1 on the boundary cycle -> no timeout, FETCH.
- rst_n=0 asserted mid-MEM_RD -> next edge state=FETCH, instret unchanged from 0, mem_req=0 while rst_n is low.
